// File: rtl/mul_rs_sched_pkg.sv
// mul_rs_sched_pkg: shared sizing defaults for the multiplier reservation station
package mul_rs_sched_pkg;
  localparam int MULRS_ENTRIES = 4;
  localparam int MULRS_TAG_W = 6;
  localparam int MULRS_DATA_W = 32;
endpackage

// File: rtl/mul_rs_sched_age.sv
// age_matrix_sel: age matrix tracking allocation order, grants the oldest requester
module age_matrix_sel #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_alloc,
  input  logic [N-1:0] i_free,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);
  // age_q[i][j] = 1 means entry i is older than entry j
  logic [N-1:0][N-1:0] age_q, age_d;
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < N; i++)
      if (i_free[i]) age_d[i] = '0;
    for (int k = 0; k < N; k++)
      if (i_alloc[k]) begin
        age_d[k] = '0;
        for (int j = 0; j < N; j++)
          if (j != k) age_d[j][k] = 1'b1;
      end
    for (int i = 0; i < N; i++) begin
      o_gnt[i] = i_req[i];
      for (int j = 0; j < N; j++)
        if (j != i && i_req[j] && !age_q[i][j]) o_gnt[i] = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) age_q <= '0;
    else age_q <= age_d;
endmodule

// File: rtl/mul_rs_sched.sv
// mul_rs_sched: reservation station and oldest-first issue scheduler for the multiplier
module mul_rs_sched
  import mul_rs_sched_pkg::*;
#(
  parameter int ENTRIES = MULRS_ENTRIES,
  parameter int TAG_W = MULRS_TAG_W,
  parameter int DATA_W = MULRS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_dp_vld,
  output logic              o_dp_rdy,
  input  logic [TAG_W-1:0]  i_dp_rob_tag,
  input  logic              i_dp_signed1,
  input  logic              i_dp_signed2,
  input  logic              i_dp_sel_high,
  input  logic              i_dp_src1_rdy,
  input  logic [DATA_W-1:0] i_dp_src1,
  input  logic              i_dp_src2_rdy,
  input  logic [DATA_W-1:0] i_dp_src2,
  input  logic              i_cdb_vld,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_data,
  input  logic              i_mul_accessable,
  output logic              o_is_vld,
  output logic              o_is_signed1,
  output logic              o_is_signed2,
  output logic              o_is_sel_high,
  output logic [DATA_W-1:0] o_is_src1,
  output logic [DATA_W-1:0] o_is_src2,
  input  logic              i_mul_exfin,
  output logic              o_wb_vld,
  output logic [TAG_W-1:0]  o_wb_rob_tag
);
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  rob_tag;
    logic              signed1;
    logic              signed2;
    logic              sel_high;
    logic              src1_rdy;
    logic [DATA_W-1:0] src1;
    logic              src2_rdy;
    logic [DATA_W-1:0] src2;
  } ent_t;
  ent_t ent_q [ENTRIES];
  ent_t ent_d [ENTRIES];
  ent_t dp_ent;
  logic [ENTRIES-1:0] valid, req, gnt, alloc_oh, alloc_en, free_oh;
  logic dp_fire, sel_en, issue, byp1, byp2;
  logic [TAG_W-1:0] win_tag;
  logic win_s1, win_s2, win_sh;
  logic [DATA_W-1:0] win_src1, win_src2;
  logic is_vld_q, is_vld_d, is_s1_q, is_s1_d, is_s2_q, is_s2_d, is_sh_q, is_sh_d;
  logic [DATA_W-1:0] is_src1_q, is_src1_d, is_src2_q, is_src2_d;
  logic inflight_q, inflight_d, killed_q, killed_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid[i] = ent_q[i].valid;
      req[i] = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
    end
    alloc_oh = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!ent_q[i].valid) begin
        alloc_oh = '0;
        alloc_oh[i] = 1'b1;
      end
    o_dp_rdy = ~rst & ~&valid;
    dp_fire = i_dp_vld & o_dp_rdy & ~i_flush;
    alloc_en = {ENTRIES{dp_fire}} & alloc_oh;
    // the multiplier needs operands held through exfin, so never issue back-to-back
    sel_en = ~is_vld_q & i_mul_accessable & ~i_flush;
  end
  age_matrix_sel #(.N(ENTRIES)) u_age (
    .clk(clk),
    .rst(rst),
    .i_alloc(alloc_en),
    .i_free(free_oh),
    .i_req(req),
    .o_gnt(gnt)
  );
  always_comb begin
    issue = sel_en & |req;
    free_oh = i_flush ? valid : ({ENTRIES{issue}} & gnt);
    win_tag = '0;
    win_s1 = 1'b0;
    win_s2 = 1'b0;
    win_sh = 1'b0;
    win_src1 = '0;
    win_src2 = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (gnt[i]) begin
        win_tag = ent_q[i].rob_tag;
        win_s1 = ent_q[i].signed1;
        win_s2 = ent_q[i].signed2;
        win_sh = ent_q[i].sel_high;
        win_src1 = ent_q[i].src1;
        win_src2 = ent_q[i].src2;
      end
    byp1 = ~i_dp_src1_rdy & i_cdb_vld & (i_dp_src1[TAG_W-1:0] == i_cdb_tag);
    byp2 = ~i_dp_src2_rdy & i_cdb_vld & (i_dp_src2[TAG_W-1:0] == i_cdb_tag);
    dp_ent.valid = 1'b1;
    dp_ent.rob_tag = i_dp_rob_tag;
    dp_ent.signed1 = i_dp_signed1;
    dp_ent.signed2 = i_dp_signed2;
    dp_ent.sel_high = i_dp_sel_high;
    dp_ent.src1_rdy = i_dp_src1_rdy | byp1;
    dp_ent.src1 = byp1 ? i_cdb_data : i_dp_src1;
    dp_ent.src2_rdy = i_dp_src2_rdy | byp2;
    dp_ent.src2 = byp2 ? i_cdb_data : i_dp_src2;
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid & ~ent_q[i].src1_rdy & i_cdb_vld & (ent_q[i].src1[TAG_W-1:0] == i_cdb_tag)) begin
        ent_d[i].src1 = i_cdb_data;
        ent_d[i].src1_rdy = 1'b1;
      end
      if (ent_q[i].valid & ~ent_q[i].src2_rdy & i_cdb_vld & (ent_q[i].src2[TAG_W-1:0] == i_cdb_tag)) begin
        ent_d[i].src2 = i_cdb_data;
        ent_d[i].src2_rdy = 1'b1;
      end
      if (free_oh[i]) ent_d[i].valid = 1'b0;
      if (alloc_en[i]) ent_d[i] = dp_ent;
    end
    is_vld_d = issue;
    is_s1_d = issue ? win_s1 : is_s1_q;
    is_s2_d = issue ? win_s2 : is_s2_q;
    is_sh_d = issue ? win_sh : is_sh_q;
    is_src1_d = issue ? win_src1 : is_src1_q;
    is_src2_d = issue ? win_src2 : is_src2_q;
    wb_tag_d = issue ? win_tag : wb_tag_q;
    inflight_d = issue ? 1'b1 : (i_mul_exfin ? 1'b0 : inflight_q);
    // a flushed op still finishes in the multiplier; only its writeback is suppressed
    killed_d = issue ? 1'b0 : (i_flush ? 1'b1 : killed_q);
  end
  always_ff @(posedge clk)
    if (rst) begin
      ent_q <= '{default: '0};
      is_vld_q <= 1'b0;
      is_s1_q <= 1'b0;
      is_s2_q <= 1'b0;
      is_sh_q <= 1'b0;
      is_src1_q <= '0;
      is_src2_q <= '0;
      wb_tag_q <= '0;
      inflight_q <= 1'b0;
      killed_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      is_vld_q <= is_vld_d;
      is_s1_q <= is_s1_d;
      is_s2_q <= is_s2_d;
      is_sh_q <= is_sh_d;
      is_src1_q <= is_src1_d;
      is_src2_q <= is_src2_d;
      wb_tag_q <= wb_tag_d;
      inflight_q <= inflight_d;
      killed_q <= killed_d;
    end
  assign o_is_vld = is_vld_q;
  assign o_is_signed1 = is_s1_q;
  assign o_is_signed2 = is_s2_q;
  assign o_is_sel_high = is_sh_q;
  assign o_is_src1 = is_src1_q;
  assign o_is_src2 = is_src2_q;
  assign o_wb_vld = i_mul_exfin & inflight_q & ~killed_q;
  assign o_wb_rob_tag = wb_tag_q;
endmodule

// File: tb/tb_mul_rs_sched.sv
// tb_mul_rs_sched: directed vectors, corner sequences and random traffic against a queue-based model
module tb_mul_rs_sched;
  logic clk = 1'b0, rst = 1'b1, i_flush = 1'b0, i_dp_vld = 1'b0, o_dp_rdy;
  logic [5:0] i_dp_rob_tag = '0, i_cdb_tag = '0, o_wb_rob_tag;
  logic i_dp_signed1 = 1'b0, i_dp_signed2 = 1'b0, i_dp_sel_high = 1'b0;
  logic i_dp_src1_rdy = 1'b0, i_dp_src2_rdy = 1'b0, i_cdb_vld = 1'b0;
  logic [31:0] i_dp_src1 = '0, i_dp_src2 = '0, i_cdb_data = '0, o_is_src1, o_is_src2;
  logic i_mul_accessable = 1'b1, i_mul_exfin = 1'b0;
  logic o_is_vld, o_is_signed1, o_is_signed2, o_is_sel_high, o_wb_vld;
  always #5 clk = ~clk;
  mul_rs_sched dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_dp_vld(i_dp_vld), .o_dp_rdy(o_dp_rdy),
    .i_dp_rob_tag(i_dp_rob_tag), .i_dp_signed1(i_dp_signed1), .i_dp_signed2(i_dp_signed2),
    .i_dp_sel_high(i_dp_sel_high), .i_dp_src1_rdy(i_dp_src1_rdy), .i_dp_src1(i_dp_src1),
    .i_dp_src2_rdy(i_dp_src2_rdy), .i_dp_src2(i_dp_src2), .i_cdb_vld(i_cdb_vld),
    .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data), .i_mul_accessable(i_mul_accessable),
    .o_is_vld(o_is_vld), .o_is_signed1(o_is_signed1), .o_is_signed2(o_is_signed2),
    .o_is_sel_high(o_is_sel_high), .o_is_src1(o_is_src1), .o_is_src2(o_is_src2),
    .i_mul_exfin(i_mul_exfin), .o_wb_vld(o_wb_vld), .o_wb_rob_tag(o_wb_rob_tag)
  );
  int errs = 0, checks = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // model: station is an age-ordered queue, oldest first
  typedef struct {
    logic [5:0] tag;
    bit s1, s2, sh, r1, r2;
    logic [31:0] v1, v2;
  } ment_t;
  ment_t q[$];
  bit m_is_vld, m_s1, m_s2, m_sh, m_inf, m_kill;
  logic [31:0] m_v1, m_v2;
  logic [5:0] m_tag;
  task automatic tick;
    bit r, fl, fire, v, cv;
    int w;
    ment_t n;
    logic [5:0] ct;
    logic [31:0] cd;
    r = rst; fl = i_flush; cv = i_cdb_vld; ct = i_cdb_tag; cd = i_cdb_data;
    fire = i_dp_vld && !rst && q.size() < 4 && !i_flush;
    w = -1;
    if (!m_is_vld && i_mul_accessable && !i_flush)
      for (int k = 0; k < q.size(); k++) if (w < 0 && q[k].r1 && q[k].r2) w = k;
    n.tag = i_dp_rob_tag; n.s1 = i_dp_signed1; n.s2 = i_dp_signed2; n.sh = i_dp_sel_high;
    n.r1 = i_dp_src1_rdy || (cv && i_dp_src1[5:0] == ct);
    n.v1 = (!i_dp_src1_rdy && cv && i_dp_src1[5:0] == ct) ? cd : i_dp_src1;
    n.r2 = i_dp_src2_rdy || (cv && i_dp_src2[5:0] == ct);
    n.v2 = (!i_dp_src2_rdy && cv && i_dp_src2[5:0] == ct) ? cd : i_dp_src2;
    v = o_is_vld;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      {m_is_vld, m_s1, m_s2, m_sh, m_inf, m_kill} = '0;
      m_v1 = '0; m_v2 = '0; m_tag = '0;
    end else begin
      for (int k = 0; k < q.size(); k++) begin
        if (!q[k].r1 && cv && q[k].v1[5:0] == ct) begin q[k].r1 = 1; q[k].v1 = cd; end
        if (!q[k].r2 && cv && q[k].v2[5:0] == ct) begin q[k].r2 = 1; q[k].v2 = cd; end
      end
      if (w >= 0) begin
        m_is_vld = 1; m_s1 = q[w].s1; m_s2 = q[w].s2; m_sh = q[w].sh;
        m_v1 = q[w].v1; m_v2 = q[w].v2; m_tag = q[w].tag; m_inf = 1; m_kill = 0;
        q.delete(w);
      end else begin
        m_is_vld = 0;
        if (i_mul_exfin) m_inf = 0;
        if (fl) m_kill = 1;
      end
      if (fl) q.delete();
      if (fire) q.push_back(n);
    end
    i_mul_exfin = v;
    #3;
    chk("dp_rdy", o_dp_rdy, !rst && q.size() < 4);
    chk("is_vld", o_is_vld, m_is_vld);
    chk("is_signed1", o_is_signed1, m_s1);
    chk("is_signed2", o_is_signed2, m_s2);
    chk("is_sel_high", o_is_sel_high, m_sh);
    chk("is_src1", o_is_src1, m_v1);
    chk("is_src2", o_is_src2, m_v2);
    chk("wb_vld", o_wb_vld, i_mul_exfin && m_inf && !m_kill);
    chk("wb_rob_tag", o_wb_rob_tag, m_tag);
  endtask
  task automatic set_dp(input logic v, input logic [5:0] t, input logic r1, input logic [31:0] a,
                        input logic r2, input logic [31:0] b);
    i_dp_vld = v; i_dp_rob_tag = t; i_dp_src1_rdy = r1; i_dp_src1 = a; i_dp_src2_rdy = r2; i_dp_src2 = b;
  endtask
  typedef struct {
    logic dp_vld; logic [5:0] tag; logic s1r; logic [31:0] s1; logic s2r; logic [31:0] s2;
    logic cdb_vld; logic [5:0] cdb_tag; logic [31:0] cdb_data;
    logic e_dp_rdy, e_is_vld; logic [31:0] e_src1, e_src2; logic e_wb_vld; logic [5:0] e_wb_tag;
  } vec_t;
  vec_t vt[11];
  int icyc[$];
  logic [31:0] isrc[$];
  initial begin
    vt[0]  = '{1, 6'h05, 1, 32'h7, 1, 32'h6, 0, 6'h00, 32'h0, 1, 0, 32'h0, 32'h0, 0, 6'h00};
    vt[1]  = '{0, 6'h00, 0, 32'h0, 0, 32'h0, 0, 6'h00, 32'h0, 1, 1, 32'h7, 32'h6, 0, 6'h05};
    vt[2]  = '{0, 6'h00, 0, 32'h0, 0, 32'h0, 0, 6'h00, 32'h0, 1, 0, 32'h7, 32'h6, 1, 6'h05};
    vt[3]  = '{0, 6'h00, 0, 32'h0, 0, 32'h0, 0, 6'h00, 32'h0, 1, 0, 32'h7, 32'h6, 0, 6'h05};
    vt[4]  = '{1, 6'h09, 0, 32'h11, 1, 32'h3, 0, 6'h00, 32'h0, 1, 0, 32'h7, 32'h6, 0, 6'h05};
    vt[5]  = '{0, 6'h00, 0, 32'h0, 0, 32'h0, 1, 6'h11, 32'hFFFFFFFE, 1, 0, 32'h7, 32'h6, 0, 6'h05};
    vt[6]  = '{0, 6'h00, 0, 32'h0, 0, 32'h0, 0, 6'h00, 32'h0, 1, 1, 32'hFFFFFFFE, 32'h3, 0, 6'h09};
    vt[7]  = '{0, 6'h00, 0, 32'h0, 0, 32'h0, 0, 6'h00, 32'h0, 1, 0, 32'hFFFFFFFE, 32'h3, 1, 6'h09};
    vt[8]  = '{1, 6'h0A, 0, 32'h12, 1, 32'h4, 1, 6'h12, 32'h55, 1, 0, 32'hFFFFFFFE, 32'h3, 0, 6'h09};
    vt[9]  = '{0, 6'h00, 0, 32'h0, 0, 32'h0, 0, 6'h00, 32'h0, 1, 1, 32'h55, 32'h4, 0, 6'h0A};
    vt[10] = '{0, 6'h00, 0, 32'h0, 0, 32'h0, 0, 6'h00, 32'h0, 1, 0, 32'h55, 32'h4, 1, 6'h0A};
    tick();
    tick();
    chk("rst_dp_rdy", o_dp_rdy, 1'b0);
    chk("rst_is_vld", o_is_vld, 1'b0);
    chk("rst_wb_tag", o_wb_rob_tag, 6'h0);
    rst = 1'b0;
    #1;
    chk("rst_drop_dp_rdy", o_dp_rdy, 1'b1);
    for (int i = 0; i < 11; i++) begin
      set_dp(vt[i].dp_vld, vt[i].tag, vt[i].s1r, vt[i].s1, vt[i].s2r, vt[i].s2);
      i_cdb_vld = vt[i].cdb_vld; i_cdb_tag = vt[i].cdb_tag; i_cdb_data = vt[i].cdb_data;
      tick();
      chk($sformatf("vec%0d_dp_rdy", i), o_dp_rdy, vt[i].e_dp_rdy);
      chk($sformatf("vec%0d_is_vld", i), o_is_vld, vt[i].e_is_vld);
      chk($sformatf("vec%0d_src1", i), o_is_src1, vt[i].e_src1);
      chk($sformatf("vec%0d_src2", i), o_is_src2, vt[i].e_src2);
      chk($sformatf("vec%0d_wb_vld", i), o_wb_vld, vt[i].e_wb_vld);
      chk($sformatf("vec%0d_wb_tag", i), o_wb_rob_tag, vt[i].e_wb_tag);
    end
    i_cdb_vld = 1'b0;
    // three ready ops back-to-back: issue every other cycle, in dispatch order
    for (int i = 1; i <= 3; i++) begin
      set_dp(1, 6'(i), 1, 32'(i), 1, 32'h10);
      tick();
      if (o_is_vld) begin icyc.push_back(i); isrc.push_back(o_is_src1); end
    end
    set_dp(0, 0, 0, 0, 0, 0);
    for (int i = 4; i < 12; i++) begin
      tick();
      if (o_is_vld) begin icyc.push_back(i); isrc.push_back(o_is_src1); end
    end
    chk("b2b_count", icyc.size(), 3);
    if (icyc.size() == 3) begin
      chk("b2b_first", icyc[0], 2);
      for (int i = 0; i < 3; i++) chk($sformatf("b2b_order%0d", i), isrc[i], 32'(i + 1));
      chk("b2b_gap1", icyc[1] - icyc[0], 2);
      chk("b2b_gap2", icyc[2] - icyc[1], 2);
    end
    // fill with non-ready ops, stall a 5th, then wake entry 2
    for (int i = 0; i < 4; i++) begin
      set_dp(1, 6'(6'h20 + i), 0, 32'(32'h20 + i), 1, 32'h2);
      tick();
    end
    set_dp(1, 6'h3F, 1, 32'h77, 1, 32'h88);
    chk("full_dp_rdy", o_dp_rdy, 1'b0);
    tick();
    tick();
    chk("full_stall_dp_rdy", o_dp_rdy, 1'b0);
    i_cdb_vld = 1'b1; i_cdb_tag = 6'h22; i_cdb_data = 32'hABC;
    tick();
    i_cdb_vld = 1'b0;
    chk("wake_not_yet", o_is_vld, 1'b0);
    tick();
    chk("wake_is_vld", o_is_vld, 1'b1);
    chk("wake_src1", o_is_src1, 32'hABC);
    chk("wake_dp_rdy", o_dp_rdy, 1'b1);
    tick();
    chk("refill_dp_rdy", o_dp_rdy, 1'b0);
    set_dp(0, 0, 0, 0, 0, 0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_empty_dp_rdy", o_dp_rdy, 1'b1);
    // flush while the op is in flight: its exfin must not write back
    i_dp_signed1 = 1'b1; i_dp_sel_high = 1'b1;
    set_dp(1, 6'h15, 1, 32'h3, 1, 32'h4);
    tick();
    set_dp(0, 0, 0, 0, 0, 0);
    i_dp_signed1 = 1'b0; i_dp_sel_high = 1'b0;
    tick();
    chk("fl_is_vld", o_is_vld, 1'b1);
    chk("fl_sel_high", o_is_sel_high, 1'b1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("fl_wb_vld", o_wb_vld, 1'b0);
    chk("fl_dp_rdy", o_dp_rdy, 1'b1);
    tick();
    chk("fl_idle", o_is_vld, 1'b0);
    // reset with three valid entries and one op in flight
    set_dp(1, 6'h31, 0, 32'h30, 1, 32'h1); tick();
    set_dp(1, 6'h32, 0, 32'h30, 1, 32'h1); tick();
    set_dp(1, 6'h33, 1, 32'h9, 1, 32'h9); tick();
    set_dp(1, 6'h34, 0, 32'h30, 1, 32'h1); tick();
    set_dp(0, 0, 0, 0, 0, 0);
    chk("rs_is_vld", o_is_vld, 1'b1);
    rst = 1'b1;
    tick();
    chk("rs_out_is_vld", o_is_vld, 1'b0);
    chk("rs_out_src1", o_is_src1, 32'h0);
    chk("rs_out_wb_vld", o_wb_vld, 1'b0);
    chk("rs_out_wb_tag", o_wb_rob_tag, 6'h0);
    chk("rs_out_dp_rdy", o_dp_rdy, 1'b0);
    rst = 1'b0;
    tick();
    chk("rs_after_dp_rdy", o_dp_rdy, 1'b1);
    for (int i = 0; i < 500; i++) begin
      i_dp_vld = $urandom_range(0, 2) != 0;
      i_dp_rob_tag = 6'($urandom);
      i_dp_signed1 = 1'($urandom); i_dp_signed2 = 1'($urandom); i_dp_sel_high = 1'($urandom);
      i_dp_src1_rdy = $urandom_range(0, 2) != 0;
      i_dp_src2_rdy = $urandom_range(0, 2) != 0;
      i_dp_src1 = i_dp_src1_rdy ? $urandom : (($urandom & ~32'h3F) | $urandom_range(0, 7));
      i_dp_src2 = i_dp_src2_rdy ? $urandom : (($urandom & ~32'h3F) | $urandom_range(0, 7));
      i_cdb_vld = 1'($urandom);
      i_cdb_tag = 6'($urandom_range(0, 7));
      i_cdb_data = $urandom;
      i_flush = $urandom_range(0, 39) == 0;
      i_mul_accessable = $urandom_range(0, 7) != 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
